program_loader: RTL
===================

Name: program_loader

Overview:
- Byte-stream boot loader for the 8-bit RISC core; it is the writer side of the 256x8 program/data memory that the core fetches from.
- Receives a framed program image, writes it into memory, and verifies a checksum.
- Holds the core stalled throughout the load, then releases it with a start pulse and an entry PC.
- Sits between the host byte channel and the memory write port, alongside the core.

Parameters:
- SYNC_BYTE, 8'hA5: frame start marker.
- RUN_AFTER_LOAD, 1: 1 = pulse cpu_start and drop cpu_hold on a good frame; 0 = keep cpu_hold high and only pulse done.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  host byte valid.
- in_data  in  8  host byte.
- in_ready  out  1  loader can accept a byte; a byte transfers on a posedge with in_valid && in_ready.
- mem_we  out  1  memory write strobe, one cycle per byte.
- mem_addr  out  8  memory write address.
- mem_wdata  out  8  memory write data.
- cpu_hold  out  1  core stall; 1 = core must not fetch.
- cpu_start  out  1  one-cycle pulse; core loads PC from entry_pc.
- entry_pc  out  8  frame start address, registered when the ADDR byte is accepted.
- done  out  1  one-cycle pulse when a frame passes its checksum.
- error  out  1  sticky checksum-failure flag.

Behaviour:
- Reset values: in_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=1, cpu_start=0, entry_pc=0, done=0, error=0, state=HUNT. Reset mid-frame aborts immediately; no further writes occur.
- Frame format: SYNC, ADDR, LEN, LEN data bytes, CSUM.
  - LEN=0 means 256 data bytes.
  - Check rule: (ADDR+LEN+sum(data)+CSUM) mod 256 == 0.
- States: HUNT -> ADDR -> LEN -> DATA -> CSUM -> FIN -> HUNT.
  - HUNT: accepted bytes other than SYNC_BYTE are discarded. SYNC_BYTE moves to ADDR, sets cpu_hold=1, clears error.
  - ADDR: wr_ptr=byte, entry_pc=byte, sum=byte.
  - LEN: count=byte (0 -> 256, so count is 9 bits), sum+=byte.
  - DATA: per accepted byte, next cycle drives mem_we=1, mem_addr=wr_ptr, mem_wdata=byte. Then wr_ptr+=1 (8-bit wrap, 8'hFF -> 8'h00), sum+=byte, count-=1. Leave for CSUM after the byte that brings count to 0.
  - CSUM: sum+=byte, go to FIN.
  - FIN: lasts one cycle, in_ready=0.
    - If sum==0: done=1 for one cycle. With RUN_AFTER_LOAD=1, cpu_start=1 in the same cycle and cpu_hold goes 0 in the same cycle and stays 0.
    - If sum!=0: error=1 (sticky until next SYNC or rst), cpu_hold stays 1, no done or start.
- Write latency: exactly 1 cycle after the data byte's accept edge. Writes are write-through; a failed frame leaves partially written memory, and cpu_hold protects the core from it.
- in_ready=1 in every state except FIN. in_valid=0 stalls the state machine with all state held. mem_we is never high in two consecutive cycles unless bytes arrive back-to-back.
- SYNC_BYTE value inside ADDR/LEN/DATA/CSUM is ordinary data; there is no resync mid-frame.
- A new frame after a successful run re-asserts cpu_hold on its SYNC byte, stalling the core again.
- Arithmetic: all sums are 8-bit modulo.

Test Plan:
- Basic load: stream A5 00 03 BF F0 90 BE back-to-back -> writes [00]=BF, [01]=F0, [02]=90 one cycle after each accept; done=cpu_start=1 for one cycle; cpu_hold 1->0; entry_pc=00; error=0.
- Address wrap: A5 FE 03 11 22 33 99 -> writes [FE]=11, [FF]=22, [00]=33; done pulse; entry_pc=FE.
- Bad checksum: A5 10 01 70 00 -> write [10]=70, error=1, done=0, cpu_start=0, cpu_hold stays 1. Then resend with CSUM 7F -> error clears at SYNC, done pulses.
- Hunt and backpressure: 00 FF 5A then a valid frame, with in_valid low for 3 cycles between each byte -> leading bytes produce no writes; the frame loads correctly with one mem_we per data byte.
- LEN=0: A5 00 00 plus 256 bytes of value k, plus matching CSUM -> 256 writes covering addresses 00..FF, then done.
- Reset mid-DATA: assert rst after the 2nd data byte -> mem_we=0 and state HUNT next cycle, cpu_hold=1; a following good frame loads normally.

Source files
------------

// File: rtl/program_loader.sv
// program_loader: byte-stream boot loader for the 8-bit core.
// Accepts frames of the form SYNC, ADDR, LEN, LEN data bytes, CSUM from a
// valid/ready host channel. Each data byte is written through to the 256x8
// program memory. A frame is good when (ADDR+LEN+sum(data)+CSUM) mod 256 == 0.
// The core is held stalled during a load and released with a start pulse
// when a frame is good.
//
// Ports:
//   clk, rst             system clock, synchronous active-high reset
//   in_valid/in_data     host byte channel; transfer when in_valid && in_ready
//   in_ready             loader can accept a byte (low only in FIN)
//   mem_we/addr/wdata    memory write port, one strobe per data byte
//   cpu_hold             core stall (1 = no fetch)
//   cpu_start            one-cycle pulse, core loads PC from entry_pc
//   entry_pc             start address of the last frame
//   done                 one-cycle pulse on a good frame
//   error                sticky checksum-failure flag, cleared by SYNC or rst
module program_loader #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter bit         RUN_AFTER_LOAD = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       mem_we,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic       cpu_hold,
    output logic       cpu_start,
    output logic [7:0] entry_pc,
    output logic       done,
    output logic       error
);

    typedef enum logic [2:0] {
        S_HUNT,
        S_ADDR,
        S_LEN,
        S_DATA,
        S_CSUM,
        S_FIN
    } state_t;

    state_t     state_q,     state_d;
    logic [7:0] wr_ptr_q,    wr_ptr_d;
    logic [8:0] count_q,     count_d;
    logic [7:0] sum_q,       sum_d;
    logic       in_ready_q,  in_ready_d;
    logic       mem_we_q,    mem_we_d;
    logic [7:0] mem_addr_q,  mem_addr_d;
    logic [7:0] mem_wdata_q, mem_wdata_d;
    logic       cpu_hold_q,  cpu_hold_d;
    logic       cpu_start_q, cpu_start_d;
    logic [7:0] entry_pc_q,  entry_pc_d;
    logic       done_q,      done_d;
    logic       error_q,     error_d;

    logic       accept_c;

    assign accept_c = in_valid && in_ready_q;

    // Next-state and registered-output computation
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        sum_d       = sum_q;
        in_ready_d  = 1'b1;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_hold_d  = cpu_hold_q;
        cpu_start_d = 1'b0;
        entry_pc_d  = entry_pc_q;
        done_d      = 1'b0;
        error_d     = error_q;

        case (state_q)
            S_HUNT: begin
                if (accept_c && (in_data == SYNC_BYTE)) begin
                    state_d    = S_ADDR;
                    cpu_hold_d = 1'b1;
                    error_d    = 1'b0;
                end
            end
            S_ADDR: begin
                if (accept_c) begin
                    wr_ptr_d   = in_data;
                    entry_pc_d = in_data;
                    sum_d      = in_data;
                    state_d    = S_LEN;
                end
            end
            S_LEN: begin
                if (accept_c) begin
                    // LEN of zero encodes a full 256-byte image
                    count_d = (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
                    sum_d   = sum_q + in_data;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (accept_c) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = wr_ptr_q;
                    mem_wdata_d = in_data;
                    wr_ptr_d    = wr_ptr_q + 8'd1;
                    sum_d       = sum_q + in_data;
                    count_d     = count_q - 9'd1;
                    if (count_q == 9'd1) begin
                        state_d = S_CSUM;
                    end
                end
            end
            S_CSUM: begin
                if (accept_c) begin
                    sum_d      = sum_q + in_data;
                    state_d    = S_FIN;
                    in_ready_d = 1'b0;
                    // Flags are set now so they are visible during the FIN cycle
                    if (sum_d == 8'd0) begin
                        done_d = 1'b1;
                        if (RUN_AFTER_LOAD) begin
                            cpu_start_d = 1'b1;
                            cpu_hold_d  = 1'b0;
                        end
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            S_FIN: begin
                state_d = S_HUNT;
            end
            default: begin
                state_d = S_HUNT;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_HUNT;
            wr_ptr_q    <= 8'd0;
            count_q     <= 9'd0;
            sum_q       <= 8'd0;
            in_ready_q  <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 8'd0;
            mem_wdata_q <= 8'd0;
            cpu_hold_q  <= 1'b1;
            cpu_start_q <= 1'b0;
            entry_pc_q  <= 8'd0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            sum_q       <= sum_d;
            in_ready_q  <= in_ready_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_hold_q  <= cpu_hold_d;
            cpu_start_q <= cpu_start_d;
            entry_pc_q  <= entry_pc_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_hold  = cpu_hold_q;
    assign cpu_start = cpu_start_q;
    assign entry_pc  = entry_pc_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule
